// File: rtl/xgmii_pktgen.sv
// XGMII 64-bit Ethernet test-frame generator: bursts of fixed-length frames with
// a sequence number in the header, an incrementing byte payload and a CRC-32 FCS.
module xgmii_pktgen #(
    parameter int MAX_FRAME_LEN = 1512,
    parameter int MIN_IFG_WORDS = 1
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [10:0] frame_len,
    input  logic [7:0]  ifg_words,
    input  logic [31:0] burst_count,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic [31:0] tx_frames
);

    localparam logic [11:0] MAX_LEN_C  = 12'(MAX_FRAME_LEN);
    localparam logic [7:0]  MIN_IFG_C  = 8'(MIN_IFG_WORDS);
    localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
    localparam logic [63:0] PRE_WORD   = 64'hd5555555555555fb;
    localparam logic [63:0] TERM_WORD  = 64'h07070707070707fd;
    localparam logic [31:0] CRC_INIT   = 32'hffffffff;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_TERM,
        S_GAP
    } state_t;

    // Reflected Ethernet CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hedb88320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] crc32_lanes(input logic [31:0] crc, input logic [63:0] data,
                                                input int nbytes);
        logic [31:0] c;
        c = crc;
        for (int l = 0; l < 8; l++) begin
            if (l < nbytes) begin
                c = crc32_byte(c, data[8*l +: 8]);
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // Bytes 0..17 come from the packed header {DA, SA, type, seq}; later bytes carry their index.
    function automatic logic [63:0] build_word(input logic [7:0] word, input logic [143:0] hdr);
        logic [63:0] w;
        logic [10:0] k;
        w = 64'd0;
        for (int l = 0; l < 8; l++) begin
            k = {word, 3'(l)};
            if (k < 11'd18) begin
                w[8*l +: 8] = 8'(hdr >> (8 * (17 - int'(k))));
            end else begin
                w[8*l +: 8] = k[7:0];
            end
        end
        return w;
    endfunction

    state_t        state_r;
    logic [7:0]    words_r;
    logic [7:0]    ifg_r;
    logic [31:0]   burst_r;
    logic [47:0]   dst_r;
    logic [47:0]   src_r;
    logic [15:0]   ety_r;
    logic [31:0]   seq_r;
    logic [31:0]   crc_r;
    logic [7:0]    word_cnt_r;
    logic [7:0]    gap_cnt_r;
    logic [31:0]   frames_in_burst_r;
    logic          stop_seen_r;

    logic          last_word_s;
    logic [143:0]  hdr_s;
    logic [63:0]   data_word_s;
    logic [63:0]   out_word_s;
    logic [31:0]   crc_tail_s;
    logic [31:0]   crc_full_s;
    logic [31:0]   crc_next_s;
    logic [7:0]    gap_len_s;
    logic          burst_end_s;
    logic          cfg_ok_s;

    // Next data word, its CRC contribution, and burst/config decisions.
    always_comb begin
        last_word_s = (word_cnt_r == (words_r - 8'd1));
        hdr_s       = {dst_r, src_r, ety_r, seq_r};
        data_word_s = build_word(word_cnt_r, hdr_s);
        crc_tail_s  = crc32_lanes(crc_r, data_word_s, 4);
        crc_full_s  = crc32_lanes(crc_r, data_word_s, 8);
        if (last_word_s) begin
            out_word_s = {~crc_tail_s, data_word_s[31:0]};
            crc_next_s = crc_tail_s;
        end else begin
            out_word_s = data_word_s;
            crc_next_s = crc_full_s;
        end
        gap_len_s   = (ifg_r > MIN_IFG_C) ? ifg_r : MIN_IFG_C;
        burst_end_s = stop_seen_r || stop ||
                      ((burst_r != 32'd0) && (frames_in_burst_r == burst_r));
        cfg_ok_s    = (frame_len[2:0] == 3'd0) && (frame_len >= 11'd64) &&
                      ({1'b0, frame_len} <= MAX_LEN_C);
    end

    // Frame sequencer; every output is a register loaded alongside the state.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r           <= S_IDLE;
            words_r           <= 8'd0;
            ifg_r             <= 8'd0;
            burst_r           <= 32'd0;
            dst_r             <= 48'd0;
            src_r             <= 48'd0;
            ety_r             <= 16'd0;
            seq_r             <= 32'd0;
            crc_r             <= CRC_INIT;
            word_cnt_r        <= 8'd0;
            gap_cnt_r         <= 8'd0;
            frames_in_burst_r <= 32'd0;
            stop_seen_r       <= 1'b0;
            xgmii_txd         <= IDLE_WORD;
            xgmii_txc         <= 8'hff;
            busy              <= 1'b0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;
            tx_frames         <= 32'd0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    xgmii_txd <= IDLE_WORD;
                    xgmii_txc <= 8'hff;
                    if (start && cfg_ok_s) begin
                        words_r           <= frame_len[10:3];
                        ifg_r             <= ifg_words;
                        burst_r           <= burst_count;
                        dst_r             <= dst_mac;
                        src_r             <= src_mac;
                        ety_r             <= ethertype;
                        seq_r             <= 32'd0;
                        crc_r             <= CRC_INIT;
                        word_cnt_r        <= 8'd0;
                        frames_in_burst_r <= 32'd0;
                        stop_seen_r       <= stop;
                        xgmii_txd         <= PRE_WORD;
                        xgmii_txc         <= 8'h01;
                        busy              <= 1'b1;
                        state_r           <= S_PREAMBLE;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_PREAMBLE, S_DATA: begin
                    stop_seen_r <= stop_seen_r | stop;
                    if ((state_r == S_DATA) && (word_cnt_r == words_r)) begin
                        xgmii_txd         <= TERM_WORD;
                        xgmii_txc         <= 8'hff;
                        tx_frames         <= tx_frames + 32'd1;
                        seq_r             <= seq_r + 32'd1;
                        frames_in_burst_r <= frames_in_burst_r + 32'd1;
                        state_r           <= S_TERM;
                    end else begin
                        xgmii_txd  <= out_word_s;
                        xgmii_txc  <= 8'h00;
                        crc_r      <= crc_next_s;
                        word_cnt_r <= word_cnt_r + 8'd1;
                        state_r    <= S_DATA;
                    end
                end
                S_TERM: begin
                    if (burst_end_s) begin
                        xgmii_txd <= IDLE_WORD;
                        xgmii_txc <= 8'hff;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= S_IDLE;
                    end else if (gap_len_s == 8'd0) begin
                        crc_r       <= CRC_INIT;
                        word_cnt_r  <= 8'd0;
                        stop_seen_r <= 1'b0;
                        xgmii_txd   <= PRE_WORD;
                        xgmii_txc   <= 8'h01;
                        state_r     <= S_PREAMBLE;
                    end else begin
                        gap_cnt_r <= gap_len_s;
                        xgmii_txd <= IDLE_WORD;
                        xgmii_txc <= 8'hff;
                        state_r   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        xgmii_txd <= IDLE_WORD;
                        xgmii_txc <= 8'hff;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= S_IDLE;
                    end else if (gap_cnt_r <= 8'd1) begin
                        crc_r       <= CRC_INIT;
                        word_cnt_r  <= 8'd0;
                        stop_seen_r <= 1'b0;
                        xgmii_txd   <= PRE_WORD;
                        xgmii_txc   <= 8'h01;
                        state_r     <= S_PREAMBLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                        xgmii_txd <= IDLE_WORD;
                        xgmii_txc <= 8'hff;
                    end
                end
                default: begin
                    xgmii_txd <= IDLE_WORD;
                    xgmii_txc <= 8'hff;
                    busy      <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_pktgen.sv
// Directed self-checking bench for xgmii_pktgen: frame contents, FCS, bursts,
// stop handling, config rejection, reset and counter wrap.
module tb_xgmii_pktgen;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hd5555555555555fb;
    localparam logic [63:0] TERM_W = 64'h07070707070707fd;

    logic        clk156 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [10:0] frame_len = 11'd64;
    logic [7:0]  ifg_words = 8'd0;
    logic [31:0] burst_count = 32'd0;
    logic [47:0] dst_mac = 48'd0;
    logic [47:0] src_mac = 48'd0;
    logic [15:0] ethertype = 16'd0;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [31:0] tx_frames;

    logic [47:0] e_da;
    logic [47:0] e_sa;
    logic [15:0] e_et;
    logic [63:0] rx_w [0:199];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk156 = ~clk156;

    xgmii_pktgen #(.MAX_FRAME_LEN(1512), .MIN_IFG_WORDS(1)) dut (
        .clk156(clk156), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .frame_len(frame_len), .ifg_words(ifg_words), .burst_count(burst_count),
        .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
        .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .busy(busy), .done(done),
        .cfg_err(cfg_err), .tx_frames(tx_frames)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_busy);
        check_val({tag, "_txc"}, {56'd0, xgmii_txc}, 64'h00000000000000ff);
        check_val({tag, "_txd"}, xgmii_txd, IDLE_W);
        check_val({tag, "_busy"}, {63'd0, busy}, {63'd0, exp_busy});
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] sq);
        if (k < 6)       return e_da[8*(5-k) +: 8];
        else if (k < 12) return e_sa[8*(11-k) +: 8];
        else if (k < 14) return e_et[8*(13-k) +: 8];
        else if (k < 18) return sq[8*(17-k) +: 8];
        else             return k[7:0];
    endfunction

    task automatic latch_expect();
        e_da = dst_mac;
        e_sa = src_mac;
        e_et = ethertype;
    endtask

    task automatic start_burst(input logic with_stop);
        @(negedge clk156);
        latch_expect();
        start = 1'b1;
        stop  = with_stop;
        @(negedge clk156);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Current sample must be the preamble; consumes data words and ends on the TERM sample.
    task automatic recv_frame(input int len, input logic [31:0] sq, input int stop_word);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [31:0] res;
        logic [63:0] w_exp;
        logic [7:0]  b;
        int          k;
        check_val("pre_txc", {56'd0, xgmii_txc}, 64'h01);
        check_val("pre_txd", xgmii_txd, PRE_W);
        check_val("pre_busy", {63'd0, busy}, 64'd1);
        crc = 32'hffffffff;
        res = 32'hffffffff;
        fcs = 32'd0;
        for (int w = 0; w < len / 8; w++) begin
            @(negedge clk156);
            stop = (w == stop_word);
            for (int l = 0; l < 8; l++) begin
                k = w * 8 + l;
                if (k < len - 4) begin
                    b   = exp_byte(k, sq);
                    crc = crc_step(crc, b);
                end else begin
                    if (k == len - 4) fcs = ~crc;
                    b = fcs[8*(k-(len-4)) +: 8];
                end
                w_exp[8*l +: 8] = b;
                res = crc_step(res, xgmii_txd[8*l +: 8]);
            end
            rx_w[w] = xgmii_txd;
            check_val("data_txc", {56'd0, xgmii_txc}, 64'd0);
            check_val("data_txd", xgmii_txd, w_exp);
        end
        check_val("fcs_residue", {32'd0, res}, {32'd0, 32'hdebb20e3});
        @(negedge clk156);
        stop = 1'b0;
        check_val("term_txc", {56'd0, xgmii_txc}, 64'hff);
        check_val("term_txd", xgmii_txd, TERM_W);
    endtask

    task automatic expect_done();
        @(negedge clk156);
        check_idle("end", 1'b0);
        check_val("done_pulse", {63'd0, done}, 64'd1);
        @(negedge clk156);
        check_val("done_clear", {63'd0, done}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $finish;
    end

    initial begin
        logic [10:0] bad_len [0:2];
        bad_len[0] = 11'd100;
        bad_len[1] = 11'd1520;
        bad_len[2] = 11'd56;

        // Reset state
        repeat (3) @(negedge clk156);
        check_idle("rst", 1'b0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
        check_val("rst_tx_frames", {32'd0, tx_frames}, 64'd0);
        sys_rst_n = 1'b1;

        // Scenario 1: single minimum frame, hand-checked header words
        frame_len = 11'd64; ifg_words = 8'd12; burst_count = 32'd1;
        dst_mac = 48'hffffffffffff; src_mac = 48'h001122334455; ethertype = 16'h0800;
        start_burst(1'b0);
        recv_frame(64, 32'd0, -1);
        check_val("s1_w0", rx_w[0], 64'h1100ffffffffffff);
        check_val("s1_w1", rx_w[1], 64'h0000000855443322);
        check_val("s1_w2", rx_w[2], 64'h1716151413120000);
        check_val("s1_w7_lo", {32'd0, rx_w[7][31:0]}, 64'h3b3a3938);
        check_val("s1_tx_frames", {32'd0, tx_frames}, 64'd1);
        expect_done();

        // Scenario 2: 3-frame burst, ifg 0 floored to 1; config changes mid-burst are ignored
        burst_count = 32'd3; ifg_words = 8'd0;
        start_burst(1'b0);
        dst_mac = 48'h0; frame_len = 11'd128; burst_count = 32'd0;
        for (int f = 0; f < 3; f++) begin
            recv_frame(64, f, -1);
            check_val("s2_seq_lo", {48'd0, rx_w[2][15:0]}, {48'd0, 8'(f), 8'h00});
            check_val("s2_tx_frames", {32'd0, tx_frames}, 64'(2 + f));
            if (f < 2) begin
                @(negedge clk156);
                check_idle("s2_gap", 1'b1);
                check_val("s2_gap_done", {63'd0, done}, 64'd0);
                @(negedge clk156);
            end
        end
        expect_done();

        // Stop during GAP ends the burst at once
        frame_len = 11'd64; dst_mac = 48'h0a0b0c0d0e0f; burst_count = 32'd0; ifg_words = 8'd3;
        start_burst(1'b0);
        recv_frame(64, 32'd0, -1);
        @(negedge clk156);
        check_idle("gap_stop_pre", 1'b1);
        stop = 1'b1;
        @(negedge clk156);
        stop = 1'b0;
        check_idle("gap_stop", 1'b0);
        check_val("gap_stop_done", {63'd0, done}, 64'd1);
        check_val("gap_stop_frames", {32'd0, tx_frames}, 64'd5);

        // Scenario 3: max-length continuous burst, stop mid-frame 5
        sys_rst_n = 1'b0;
        @(negedge clk156);
        sys_rst_n = 1'b1;
        frame_len = 11'd1512; burst_count = 32'd0; ifg_words = 8'd2;
        start_burst(1'b0);
        for (int f = 0; f < 5; f++) begin
            recv_frame(1512, f, (f == 4) ? 100 : -1);
            if (f < 4) begin
                repeat (2) begin
                    @(negedge clk156);
                    check_idle("s3_gap", 1'b1);
                end
                @(negedge clk156);
            end
        end
        expect_done();
        check_val("s3_tx_frames", {32'd0, tx_frames}, 64'd5);

        // Scenario 4: rejected configurations; stop alone in IDLE does nothing
        for (int i = 0; i < 3; i++) begin
            frame_len = bad_len[i];
            @(negedge clk156);
            start = 1'b1;
            @(negedge clk156);
            start = 1'b0;
            check_val("s4_cfg_err", {63'd0, cfg_err}, 64'd1);
            check_idle("s4_out", 1'b0);
            @(negedge clk156);
            check_val("s4_cfg_err_clr", {63'd0, cfg_err}, 64'd0);
        end
        stop = 1'b1;
        @(negedge clk156);
        stop = 1'b0;
        @(negedge clk156);
        check_idle("idle_stop", 1'b0);
        check_val("idle_stop_done", {63'd0, done}, 64'd0);

        // Scenario 5: asynchronous reset during frame 2, then restart from seq 0
        frame_len = 11'd64; burst_count = 32'd0; ifg_words = 8'd1;
        start_burst(1'b0);
        recv_frame(64, 32'd0, -1);
        @(negedge clk156);
        @(negedge clk156);
        check_val("s5_pre2", {56'd0, xgmii_txc}, 64'h01);
        repeat (3) @(negedge clk156);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_idle("s5_rst", 1'b0);
        check_val("s5_rst_frames", {32'd0, tx_frames}, 64'd0);
        @(negedge clk156);
        sys_rst_n = 1'b1;
        burst_count = 32'd1;
        latch_expect();
        start = 1'b1;
        @(negedge clk156);
        start = 1'b0;
        recv_frame(64, 32'd0, -1);
        check_val("s5_restart_frames", {32'd0, tx_frames}, 64'd1);
        expect_done();

        // Scenario 6: counter wrap; start+stop together sends exactly one frame
        force dut.tx_frames = 32'hffffffff;
        #1;
        release dut.tx_frames;
        check_val("s6_preload", {32'd0, tx_frames}, 64'hffffffff);
        burst_count = 32'd0;
        start_burst(1'b1);
        recv_frame(64, 32'd0, -1);
        check_val("s6_wrap", {32'd0, tx_frames}, 64'd0);
        expect_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xgmii_pktgen.md
XGMII_PKTGEN -- requirements
Module: xgmii_pktgen

Interface
REQ-001 Parameter MAX_FRAME_LEN, default 1512, largest accepted frame length in bytes (DA through FCS).
REQ-002 Parameter MIN_IFG_WORDS, default 1, floor applied to the requested inter-frame gap.
REQ-003 clk156  in  1  156.25 MHz XGMII clock; all logic on its rising edge.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  level sampled in IDLE; starts a burst.
REQ-006 stop  in  1  request to end the burst after the current frame.
REQ-007 frame_len  in  11  frame bytes incl. FCS, excl. preamble/SFD; latched at start.
REQ-008 ifg_words  in  8  idle words between frames; latched at start.
REQ-009 burst_count  in  32  frames per burst, 0 = continuous; latched at start.
REQ-010 dst_mac, src_mac  in  48 each  header fields; latched at start.
REQ-011 ethertype  in  16  header field; latched at start.
REQ-012 xgmii_txd  out  64  lane 0 = txd[7:0], first byte on wire.
REQ-013 xgmii_txc  out  8  control flag per lane.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when a burst ends.
REQ-016 cfg_err  out  1  one-cycle pulse when start is rejected.
REQ-017 tx_frames  out  32  frames completed since reset, wraps at 2^32.

Function
REQ-018 All outputs registered; IDLE drives txc=8'hff, txd=8x 8'h07.
REQ-019 FSM states: IDLE, PREAMBLE, DATA, TERM, GAP.
REQ-020 IDLE with start=1 and valid config: latch config, clear seq, go to PREAMBLE.
REQ-021 Output latency: preamble word appears on the cycle after start is sampled.
REQ-022 Valid config: frame_len multiple of 8, 64 <= frame_len <= MAX_FRAME_LEN; otherwise pulse cfg_err, stay in IDLE.
REQ-023 PREAMBLE word: txc=8'h01, txd=64'hd5555555555555fb.
REQ-024 DATA: frame_len/8 words, txc=8'h00; frame byte k is placed on lane k mod 8.
REQ-025 Byte order: bytes 0-5 dst_mac MSB first, 6-11 src_mac, 12-13 ethertype MSB first, 14-17 seq MSB first, byte k>=18 = k[7:0].
REQ-026 Last 4 bytes are the FCS: Ethernet CRC-32 (reflected poly 0x04C11DB7, init 0xFFFFFFFF, final complement) over bytes 0..frame_len-5, transmitted LSB first.
REQ-027 CRC is updated 8 bytes per cycle, except the final DATA word, which updates over lanes 0-3 only.
REQ-028 TERM word: txc=8'hff, txd=64'h07070707070707fd; tx_frames increments and seq increments (32-bit wrap) in this cycle.
REQ-029 GAP: max(ifg_words, MIN_IFG_WORDS) idle words, then PREAMBLE of the next frame.
REQ-030 Burst end: after TERM, if stop was seen since the last PREAMBLE, or burst_count != 0 and frames in burst == burst_count, go to IDLE (no GAP) and pulse done.
REQ-031 stop never truncates a frame; stop asserted in GAP ends the burst immediately (go to IDLE, pulse done).
REQ-032 stop in IDLE has no effect; start and stop both high in IDLE starts the burst, and the burst then ends after its first frame.
REQ-033 Config input changes while busy have no effect on the burst in progress.

Reset
REQ-034 Asserting sys_rst_n low at any time forces IDLE immediately, with idle XGMII, busy=0, done=0, cfg_err=0, tx_frames=0, seq=0, CRC=0xFFFFFFFF.
REQ-035 A frame cut by reset is not counted, and no terminate word is emitted.
REQ-036 After reset deasserts, the first start is accepted on the first rising edge.

Verification
REQ-037 Scenario 1: frame_len=64, ifg=12, burst=1, DA=ff..ff, SA=00_11_22_33_44_55, type 0800, start -> words are preamble, 8 DATA, TERM; FCS matches the reference CRC-32; done 1 cycle after TERM; tx_frames=1.
REQ-038 Scenario 2: burst=3, ifg=0 -> 3 frames with exactly 1 idle word between them, seq 0,1,2, done once, busy low after the third TERM.
REQ-039 Scenario 3: frame_len=1512, burst=0, stop pulsed mid-DATA of frame 5 -> frame 5 completes with TERM, no GAP, IDLE, tx_frames=5.
REQ-040 Scenario 4: frame_len=100, then 1520, then 56 -> cfg_err pulse for each, busy stays 0, output idle.
REQ-041 Scenario 5: sys_rst_n low during DATA of frame 2 -> idle word output without waiting for a clock, tx_frames=0; restart yields seq=0.
REQ-042 Scenario 6: tx_frames preloaded (forced) to 32'hffffffff, then one frame sent -> tx_frames=0.
